kiwi_biu_arb: RTL and testbench

- Two-requester memory-port arbiter. Shares one memory request/response port between the instruction BIU (master 0, ibiu) and the data BIU (master 1, dbiu).
- Sits in kiwi_subsys between the BIUs and the single external memory bridge.
- Arbitrates requests round-robin, holds a grant until the request is accepted, and tracks outstanding requests in an in-order ID FIFO so each response returns to its issuer.

---
 rtl/kiwi_biu_arb.sv | 182 ++++++++++++++++++
 tb/tb_kiwi_biu_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kiwi_biu_arb.sv
// kiwi_biu_arb: shares one memory request/response port between the
// instruction BIU (master 0) and the data BIU (master 1).
//
// Requests are arbitrated round-robin. A grant is held until the memory
// accepts it. Issuers are recorded in an in-order ID FIFO so that each
// response is routed back to the master that made the request.
//
// Optional build macro KIWI_BIU_ARB_DPRIO_EN: fixed priority, so that the
// dbiu (master 1) always wins a tie. A grant that is already held still
// cannot be preempted.
//
// Grant lock state:
//   lock_q | meaning
//   -------+-------------------------------------------------------------
//   0      | free: the selection follows the arbitration rule
//   1      | held: a request was presented but not accepted; lock_id_q
//          | stays selected until memory accepts the request
module kiwi_biu_arb #(
    parameter int AW          = 64,
    parameter int DW          = 64,
    parameter int OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            m_req_valid,
    output logic [1:0]            m_req_ready,
    input  logic [1:0]            m_req_we,
    input  logic [2*AW-1:0]       m_req_addr,
    input  logic [2*DW-1:0]       m_req_wdata,
    input  logic [2*(DW/8)-1:0]   m_req_wstrb,
    output logic [1:0]            m_rsp_valid,
    output logic [DW-1:0]         m_rsp_rdata,
    output logic                  s_req_valid,
    input  logic                  s_req_ready,
    output logic                  s_req_we,
    output logic [AW-1:0]         s_req_addr,
    output logic [DW-1:0]         s_req_wdata,
    output logic [DW/8-1:0]       s_req_wstrb,
    input  logic                  s_rsp_valid,
    input  logic [DW-1:0]         s_rsp_rdata,
    output logic                  orphan_rsp
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = DW / 8;

    logic                   lock_q, lock_d;
    logic                   lock_id_q, lock_id_d;
`ifndef KIWI_BIU_ARB_DPRIO_EN
    logic                   rr_ptr_q, rr_ptr_d;
`endif
    logic [OUTSTANDING-1:0] id_q, id_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   full_q, full_d;
    logic                   orphan_q, orphan_d;

    logic                   sel;
    logic                   req_ok;
    logic                   accept;
    logic                   fifo_empty;
    logic                   pop;
    logic                   head_id;

    // Choose the master: a held grant wins; otherwise arbitrate the ties.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (&m_req_valid) begin
`ifdef KIWI_BIU_ARB_DPRIO_EN
            sel = 1'b1;
`else
            sel = ~rr_ptr_q;
`endif
        end else begin
            sel = m_req_valid[1];
        end
    end

    // Forward the selected request. The outputs are forced idle while reset is held.
    always_comb begin
        req_ok      = m_req_valid[sel] & ~full_q;
        accept      = req_ok & s_req_ready;
        s_req_valid = req_ok & rst_n;
        s_req_we    = sel ? m_req_we[1] : m_req_we[0];
        s_req_addr  = sel ? m_req_addr[2*AW-1:AW] : m_req_addr[AW-1:0];
        s_req_wdata = sel ? m_req_wdata[2*DW-1:DW] : m_req_wdata[DW-1:0];
        s_req_wstrb = sel ? m_req_wstrb[2*SW-1:SW] : m_req_wstrb[SW-1:0];
        m_req_ready = 2'b00;
        if (rst_n && !full_q && s_req_ready) begin
            m_req_ready[sel] = 1'b1;
        end
    end

    // Route each memory response to the oldest outstanding issuer.
    always_comb begin
        fifo_empty  = (count_q == '0);
        pop         = s_rsp_valid & ~fifo_empty;
        head_id     = id_q[rd_ptr_q];
        m_rsp_rdata = s_rsp_rdata;
        m_rsp_valid = 2'b00;
        if (pop) begin
            m_rsp_valid[head_id] = 1'b1;
        end
    end

    // Next state for the grant lock, the arbitration pointer, the ID FIFO and the orphan flag.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (req_ok) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

`ifndef KIWI_BIU_ARB_DPRIO_EN
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = sel;
        end
`endif

        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            id_d[wr_ptr_q] = sel;
            wr_ptr_d       = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // full is taken from the registered count, so a pop frees a slot one cycle later.
        full_d   = (count_d == CW'(OUTSTANDING));
        orphan_d = orphan_q | (s_rsp_valid & fifo_empty);
    end

    // State registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
`ifndef KIWI_BIU_ARB_DPRIO_EN
            rr_ptr_q  <= 1'b1;
`endif
            id_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`ifndef KIWI_BIU_ARB_DPRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
            id_q      <= id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            orphan_q  <= orphan_d;
        end
    end

    assign orphan_rsp = orphan_q;

endmodule

// File: tb/tb_kiwi_biu_arb.sv
// Self-checking bench for kiwi_biu_arb. A vector table covers arbitration
// and the grant lock. Hand-written sequences cover the held grant, a full
// FIFO, response routing, orphan responses and a reset applied mid-stream.
// A scoreboard queue holds the expected response of each accepted request.
module tb_kiwi_biu_arb;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

`ifdef KIWI_BIU_ARB_DPRIO_EN
    localparam bit DP = 1'b1;
`else
    localparam bit DP = 1'b0;
`endif

    localparam logic [AW-1:0] A0 = 64'h0000_0000_0000_1000;
    localparam logic [AW-1:0] A1 = 64'h0000_0000_0000_2000;
    localparam logic [DW-1:0] W0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] W1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [SW-1:0] S0 = 8'h0F;
    localparam logic [SW-1:0] S1 = 8'hF0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        m_req_valid;
    logic [1:0]        m_req_ready;
    logic [1:0]        m_req_we;
    logic [2*AW-1:0]   m_req_addr;
    logic [2*DW-1:0]   m_req_wdata;
    logic [2*SW-1:0]   m_req_wstrb;
    logic [1:0]        m_rsp_valid;
    logic [DW-1:0]     m_rsp_rdata;
    logic              s_req_valid;
    logic              s_req_ready;
    logic              s_req_we;
    logic [AW-1:0]     s_req_addr;
    logic [DW-1:0]     s_req_wdata;
    logic [SW-1:0]     s_req_wstrb;
    logic              s_rsp_valid;
    logic [DW-1:0]     s_rsp_rdata;
    logic              orphan_rsp;

    kiwi_biu_arb #(.AW(AW), .DW(DW), .OUTSTANDING(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_we    (m_req_we),
        .m_req_addr  (m_req_addr),
        .m_req_wdata (m_req_wdata),
        .m_req_wstrb (m_req_wstrb),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_rdata (m_rsp_rdata),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_we    (s_req_we),
        .s_req_addr  (s_req_addr),
        .s_req_wdata (s_req_wdata),
        .s_req_wstrb (s_req_wstrb),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_rdata (s_rsp_rdata),
        .orphan_rsp  (orphan_rsp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        logic [1:0] v;
        logic       rdy;
        logic       rsp;
        logic [1:0] er;
        logic       esv;
        logic       esel;
    } vec_t;

    sb_t           sb[$];
    vec_t          tbl[9];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] next_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive the inputs after the edge, check the combinational outputs, then advance to the next edge.
    task automatic step(input string nm, input logic [1:0] v, input logic rdy, input logic rsp,
                        input logic [1:0] exp_rdy, input logic exp_sv, input logic exp_sel);
        sb_t e;
        m_req_valid = v;
        s_req_ready = rdy;
        s_rsp_valid = rsp;
        s_rsp_rdata = (rsp && sb.size() > 0) ? sb[0].data : 64'h0BAD_0BAD_0BAD_0BAD;
        #3;
        chk({nm, "/m_req_ready"}, 64'(m_req_ready), 64'(exp_rdy));
        chk({nm, "/s_req_valid"}, 64'(s_req_valid), 64'(exp_sv));
        if (exp_sv) begin
            chk({nm, "/s_req_addr"},  s_req_addr, exp_sel ? A1 : A0);
            chk({nm, "/s_req_we"},    64'(s_req_we), 64'(m_req_we[exp_sel]));
            chk({nm, "/s_req_wdata"}, s_req_wdata, exp_sel ? W1 : W0);
            chk({nm, "/s_req_wstrb"}, 64'(s_req_wstrb), 64'(exp_sel ? S1 : S0));
        end
        if (rsp && sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, "/m_rsp_valid"}, 64'(m_rsp_valid), e.id ? 64'h2 : 64'h1);
            chk({nm, "/m_rsp_rdata"}, m_rsp_rdata, e.data);
        end else begin
            chk({nm, "/m_rsp_valid"}, 64'(m_rsp_valid), 64'h0);
        end
        if (exp_sv && rdy) begin
            e.id   = exp_sel;
            e.data = next_data;
            sb.push_back(e);
            next_data = next_data + 64'h1111;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset with both masters and a response active, and check that the outputs go idle at once.
    task automatic do_reset(input string nm);
        rst_n       = 1'b0;
        m_req_valid = 2'b11;
        s_req_ready = 1'b1;
        s_rsp_valid = 1'b1;
        #2;
        chk({nm, "/m_req_ready"}, 64'(m_req_ready), 64'h0);
        chk({nm, "/s_req_valid"}, 64'(s_req_valid), 64'h0);
        chk({nm, "/m_rsp_valid"}, 64'(m_rsp_valid), 64'h0);
        chk({nm, "/orphan_rsp"},  64'(orphan_rsp), 64'h0);
        sb.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk({nm, "/orphan_hold"}, 64'(orphan_rsp), 64'h0);
        m_req_valid = 2'b00;
        s_rsp_valid = 1'b0;
        s_req_ready = 1'b0;
        rst_n       = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_req_valid = 2'b00;
        m_req_we    = 2'b00;
        m_req_addr  = {A1, A0};
        m_req_wdata = {W1, W0};
        m_req_wstrb = {S1, S0};
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        s_rsp_rdata = '0;
        next_data   = 64'h0000_0000_DEAD_BEEF;

        // Ties with rr_ptr reset to 1: m0, m1, m0, m1 (always m1 with fixed priority).
        for (int i = 0; i < 4; i++) begin
            tbl[i].v    = 2'b11;
            tbl[i].rdy  = 1'b1;
            tbl[i].rsp  = (i != 0);
            tbl[i].esv  = 1'b1;
            tbl[i].esel = DP ? 1'b1 : i[0];
            tbl[i].er   = tbl[i].esel ? 2'b10 : 2'b01;
        end
        tbl[4] = '{v: 2'b00, rdy: 1'b1, rsp: 1'b1, er: 2'b01, esv: 1'b0, esel: 1'b0};
        tbl[5] = '{v: 2'b10, rdy: 1'b0, rsp: 1'b0, er: 2'b00, esv: 1'b1, esel: 1'b1};
        tbl[6] = '{v: 2'b11, rdy: 1'b1, rsp: 1'b0, er: 2'b10, esv: 1'b1, esel: 1'b1};
        tbl[7] = '{v: 2'b01, rdy: 1'b1, rsp: 1'b1, er: 2'b01, esv: 1'b1, esel: 1'b0};
        tbl[8] = '{v: 2'b00, rdy: 1'b1, rsp: 1'b1, er: 2'b01, esv: 1'b0, esel: 1'b0};

        do_reset("rst0");
        step("t1_req", 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        step("t1_rsp", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("t1_orphan", 64'(orphan_rsp), 64'h0);

        do_reset("rst1");
        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].rdy, tbl[i].rsp,
                 tbl[i].er, tbl[i].esv, tbl[i].esel);
        end
        chk("vec_orphan", 64'(orphan_rsp), 64'h0);

        // Held grant: m0 stalls three cycles; m1 joins and must wait.
        step("lk1", 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        step("lk2", 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        step("lk3", 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        step("lk4", 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        step("lk5", 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
        step("lk_r0", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        step("lk_r1", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);

        // Full FIFO: four requests accepted, the fifth blocked, still blocked in the cycle of a pop.
        for (int i = 0; i < 4; i++) begin
            step($sformatf("fill%0d", i), 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        end
        step("full_blk", 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        step("full_pop", 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        step("full_go",  2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("drain%0d", i), 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        end

        // Routing: m0 write, m1 read, m0 read, then responses in order.
        m_req_we = 2'b01;
        step("rt_w0", 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        m_req_we = 2'b00;
        step("rt_r1", 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
        step("rt_r0", 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("rt_rsp%0d", i), 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        end

        // Orphan response, which is sticky.
        step("orph", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("orph_set", 64'(orphan_rsp), 64'h1);
        step("orph_idle", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("orph_sticky", 64'(orphan_rsp), 64'h1);

        // Reset with two requests outstanding; afterwards a response must find the FIFO empty.
        step("mid_a", 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        step("mid_b", 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        do_reset("rst_mid");
        step("post_rst", 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("post_rst_orphan", 64'(orphan_rsp), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
